// File: rtl/noc_pkg.sv
// Shared NoC definitions: field widths, packet slices and the flit layout
// reused by the transmit/receive interfaces and the router.
package noc_pkg;
    localparam int NODE_ID_W  = 4;
    localparam int PKT_W      = 12;
    localparam int FLIT_W     = 16;

    localparam int DEST_HI    = 11;
    localparam int DEST_LO    = 8;
    localparam int PAYLOAD_HI = 7;
    localparam int PAYLOAD_LO = 0;

    typedef struct packed {
        logic [NODE_ID_W-1:0]             src;
        logic [NODE_ID_W-1:0]             dest;
        logic [PAYLOAD_HI-PAYLOAD_LO:0]   payload;
    } flit_t;

    function automatic flit_t makeFlit(input logic [NODE_ID_W-1:0] src,
                                       input logic [PKT_W-1:0]     pkt);
        flit_t f;
        f.src     = src;
        f.dest    = pkt[DEST_HI:DEST_LO];
        f.payload = pkt[PAYLOAD_HI:PAYLOAD_LO];
        return f;
    endfunction
endpackage

// File: rtl/noc_tx_interface_fifo.sv
// Small synchronous FIFO with a separately tracked occupancy count; a push
// into a full FIFO is accepted only when a pop frees the head slot that cycle.
module noc_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wrData,
    output logic [WIDTH-1:0]         rdData,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic             doPop;
    logic             doPush;

    assign empty  = (count == '0);
    assign full   = (count == CNT_W'(DEPTH));
    assign doPop  = pop && !empty;
    assign doPush = push && (!full || doPop);
    assign rdData = mem[rdPtr];

    // Storage is intentionally left out of reset.
    always_ff @(posedge clk) begin
        if (doPush)
            mem[wrPtr] <= wrData;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush)
                wrPtr <= wrPtr + PTR_W'(1);
            if (doPop)
                rdPtr <= rdPtr + PTR_W'(1);
            case ({doPush, doPop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/noc_tx_interface.sv
// Transmit-side network interface: buffers core packets, tags them with the
// local node ID and offers them to the router on a valid/ready handshake.
module noc_tx_interface
    import noc_pkg::*;
#(
    parameter logic [NODE_ID_W-1:0] SRC_ID = 4'd0,
    parameter int                   DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     noc_write,
    input  logic [31:0]              noc_packet,
    output logic                     flit_valid,
    output logic [FLIT_W-1:0]        flit_data,
    input  logic                     flit_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     full,
    output logic [7:0]               drop_count
);
    logic [FLIT_W-1:0] headFlit;
    logic [FLIT_W-1:0] newFlit;
    logic              empty;
    logic              pop;
    logic              dropEv;
    logic              unusedHi;

    assign unusedHi = ^noc_packet[31:PKT_W];
    assign newFlit  = makeFlit(SRC_ID, noc_packet[PKT_W-1:0]);

    assign flit_valid = !empty;
    assign flit_data  = flit_valid ? headFlit : '0;
    assign pop        = flit_valid && flit_ready;
    assign dropEv     = noc_write && full && !pop;

    noc_fifo #(
        .WIDTH (FLIT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (noc_write),
        .pop    (pop),
        .wrData (newFlit),
        .rdData (headFlit),
        .count  (fifo_count),
        .full   (full),
        .empty  (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            drop_count <= '0;
        else if (dropEv && drop_count != 8'hFF)
            drop_count <= drop_count + 8'd1;
    end
endmodule
